// File: rtl/riscy_pkg.sv
// Shared definitions for the riscy core: bus widths and the fetch-stage state type.
package riscy_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, word} entries between the fetch
// stage and decode. The head entry is readable combinationally. A clear drops
// all entries and takes priority over a push or pop in the same cycle.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = riscy_pkg::ADDR_W + riscy_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    import riscy_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_push = push && (count != FULL_COUNT);
        do_pop  = pop && (count != '0);
    end

    // Pointer, count and storage update; clear discards everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[PTR_W'(i)] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: issues one memory read at a time for the current PC,
// buffers returned words with their address, and hands them to decode over a
// valid/ready handshake. inc_en advances the PC once per kept fetch; a flush
// (taken jump) discards buffered words and any read still in flight.
module ifetch #(
    parameter int ADDR_W    = riscy_pkg::ADDR_W,
    parameter int DATA_W    = riscy_pkg::DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              inc_en,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    import riscy_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(BUF_DEPTH);

    fetch_state_t               state;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W+DATA_W-1:0]   head;
    logic                       push;
    logic                       pop;

    // A word is kept (and the PC advanced) only when it returns for a live request.
    always_comb begin
        inc_en      = (state == REQ) && mem_ack && !flush;
        push        = inc_en;
        instr_valid = (count != '0);
        pop         = instr_valid && instr_ready;
    end

    // Fetch sequencing: issue from IDLE, keep data in REQ, throw it away in DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && (count < DEPTH_COUNT)) begin
                        mem_addr <= pc_addr;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        // Memory cannot abort: keep the request up and discard its data later.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({mem_addr, mem_rdata}),
        .pop       (pop),
        .clear     (flush),
        .count     (count),
        .head      (head)
    );

    assign {instr_pc, instr} = head;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: models the PC and instruction memory around the fetch stage,
// predicts delivered {pc, word} pairs into a queue, and checks them as decode
// accepts them, alongside directed scenarios for backpressure, flushes and reset.
module tb_ifetch;

    import riscy_pkg::*;

    localparam int BUF_DEPTH = 2;
    localparam int W = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic              inc_en;
    logic              flush = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    always #5 clk = ~clk;

    ifetch #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .inc_en      (inc_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle-time %0t)", name, got, exp, $time);
        end
    endtask

    // Memory contents: every address holds its own value plus 0x100.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h100 + DATA_W'(a);
    endfunction

    // Stimulus knobs
    int  lat_min = 1, lat_max = 1;
    int  ready_pct = 100, flush_pct = 0;
    int  flush_at_age = 0;
    bit  flush_need_valid = 1'b0;
    bit  ready_on_ack = 1'b0;
    bit  nxt_reset = 1'b1;
    bit  one_shot_flush = 1'b0;
    logic [ADDR_W-1:0] one_shot_target = '0;

    // Environment / reference state
    logic [ADDR_W-1:0] pc_model = '0;
    logic [ADDR_W-1:0] tgt = '0;
    int  age = 0, cur_lat = 1, cyc = 0;
    logic [W-1:0] exp_q[$];
    bit  seen_req = 1'b0, tainted = 1'b0;
    logic [ADDR_W-1:0] issue_pc = '0;
    logic [ADDR_W-1:0] last_issue_addr = '0;
    int  issue_cnt = 0, inc_seen = 0;
    bit  t4_hit = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        int                c;
    } pop_t;
    pop_t pop_log[$];

    // One clock cycle: drive inputs after the edge, update models before the next.
    task automatic cycle();
        bit fl;
        bit ack;
        bit exp_inc;
        @(posedge clk);
        #1;
        cyc++;
        reset   = nxt_reset;
        pc_addr = pc_model;
        ack = 1'b0;
        if (reset || !mem_req) begin
            age = 0;
        end else begin
            age++;
            if (age == 1) cur_lat = int'($urandom_range(lat_max, lat_min));
            ack = (age >= cur_lat);
        end
        mem_ack   = ack;
        mem_rdata = ack ? mem_word(mem_addr) : $urandom;
        fl  = 1'b0;
        tgt = ADDR_W'($urandom);
        if (one_shot_flush) begin
            fl = 1'b1;
            tgt = one_shot_target;
            one_shot_flush = 1'b0;
        end else if (flush_at_age != 0 && mem_req && age == flush_at_age &&
                     (!flush_need_valid || instr_valid)) begin
            fl = 1'b1;
            tgt = one_shot_target;
            flush_at_age = 0;
        end else if (int'($urandom_range(99, 0)) < flush_pct) begin
            fl = 1'b1;
        end
        if (reset) fl = 1'b0;
        flush = fl;
        instr_ready = ready_on_ack ? ack : (int'($urandom_range(99, 0)) < ready_pct);
        if (fl && ack && instr_valid && instr_ready) t4_hit = 1'b1;
        if (ack) age = 0;

        @(negedge clk);
        #1;
        if (inc_en) inc_seen++;
        if (reset) begin
            exp_q.delete();
            seen_req = 1'b0;
            tainted  = 1'b0;
            pc_model = '0;
        end else begin
            if (mem_req && !seen_req) begin
                seen_req = 1'b1;
                tainted  = 1'b0;
                issue_pc = pc_model;
                last_issue_addr = mem_addr;
                issue_cnt++;
                chk("issue_addr", 64'(mem_addr), 64'(pc_model));
                chk("issue_room", 64'(exp_q.size() < BUF_DEPTH), 64'(1));
            end else if (mem_req) begin
                chk("addr_stable", 64'(mem_addr), 64'(issue_pc));
            end
            exp_inc = mem_ack && !flush && !tainted && seen_req;
            chk("inc_en", 64'(inc_en), 64'(exp_inc));
            if (exp_inc) exp_q.push_back({issue_pc, mem_word(issue_pc)});
            if (mem_req && flush) tainted = 1'b1;
            if (mem_ack) begin
                seen_req = 1'b0;
                tainted  = 1'b0;
            end
            if (flush) exp_q.delete();
            if (flush) pc_model = tgt;
            else if (inc_en) pc_model = pc_model + 1'b1;
        end
    endtask

    // Monitor: compares each word decode accepts against the predicted queue.
    initial begin : monitor
        logic [W-1:0]      e;
        bit                hold;
        logic [ADDR_W-1:0] hpc;
        logic [DATA_W-1:0] hw;
        pop_t              p;
        hold = 1'b0;
        hpc = '0;
        hw = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("valid_vs_model", 64'(instr_valid), 64'(exp_q.size() != 0));
                if (hold) begin
                    chk("hold_valid", 64'(instr_valid), 64'(1));
                    chk("hold_pc", 64'(instr_pc), 64'(hpc));
                    chk("hold_instr", 64'(instr), 64'(hw));
                end
                if (instr_valid && instr_ready && !flush && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("instr_pc", 64'(instr_pc), 64'(e[W-1:DATA_W]));
                    chk("instr", 64'(instr), 64'(e[DATA_W-1:0]));
                    p.pc = instr_pc;
                    p.c  = cyc;
                    pop_log.push_back(p);
                end
            end
            hold = !reset && !flush && instr_valid && !instr_ready;
            hpc  = instr_pc;
            hw   = instr;
        end
    end

    task automatic do_reset();
        nxt_reset = 1'b1;
        cycle();
        nxt_reset = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pop_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(name, 64'(pop_log.size() >= n), 64'(1));
    endtask

    initial begin : main
        int c0;
        int k;
        int prev_issues;

        // Reset state
        cycle();
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_instr_pc", 64'(instr_pc), 64'(0));
        chk("rst_inc_en", 64'(inc_en), 64'(0));

        // 1: free-run from PC 0, one word every two cycles
        nxt_reset = 1'b0;
        pop_log.delete();
        inc_seen = 0;
        c0 = cyc + 1;
        for (int i = 0; i < 12; i++) cycle();
        chk("t1_pops", 64'(pop_log.size()), 64'(5));
        chk("t1_incs", 64'(inc_seen), 64'(6));
        for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
            chk("t1_pc_seq", 64'(pop_log[i].pc), 64'(i));
            chk("t1_cycle", 64'(pop_log[i].c), 64'(c0 + 2 + 2 * i));
        end

        // 2: backpressure fills the buffer and stops fetching
        ready_pct = 0;
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        chk("t2_mem_req", 64'(mem_req), 64'(0));
        chk("t2_pc", 64'(pc_model), 64'(2));
        chk("t2_buffered", 64'(exp_q.size()), 64'(2));
        chk("t2_valid", 64'(instr_valid), 64'(1));
        chk("t2_instr", 64'(instr), 64'(32'h100));
        chk("t2_instr_pc", 64'(instr_pc), 64'(0));
        ready_pct = 100;
        pop_log.delete();
        wait_pops(3, 30, "t2_drain_done");
        for (int i = 0; i < 3 && i < pop_log.size(); i++)
            chk("t2_order", 64'(pop_log[i].pc), 64'(i));

        // 3: flush with a slow request in flight
        lat_min = 4;
        lat_max = 4;
        do_reset();
        one_shot_target = 14'h200;
        flush_at_age = 2;
        k = 0;
        while (flush_at_age != 0 && k < 50) begin
            cycle();
            k++;
        end
        chk("t3_flush_fired", 64'(flush_at_age == 0), 64'(1));
        chk("t3_inc_in_flush", 64'(inc_en), 64'(0));
        cycle();
        chk("t3_fifo_empty", 64'(instr_valid), 64'(0));
        prev_issues = issue_cnt;
        k = 0;
        while (issue_cnt == prev_issues && k < 40) begin
            cycle();
            k++;
        end
        chk("t3_next_addr", 64'(last_issue_addr), 64'(14'h200));
        pop_log.delete();
        wait_pops(1, 40, "t3_first_word");
        if (pop_log.size() != 0) chk("t3_first_pc", 64'(pop_log[0].pc), 64'(14'h200));

        // 4: flush coinciding with an ack and a head pop
        lat_min = 3;
        lat_max = 3;
        ready_pct = 0;
        ready_on_ack = 1'b1;
        flush_need_valid = 1'b1;
        do_reset();
        one_shot_target = 14'h40;
        flush_at_age = 3;
        t4_hit = 1'b0;
        k = 0;
        while (flush_at_age != 0 && k < 60) begin
            cycle();
            k++;
        end
        chk("t4_coincident", 64'(t4_hit), 64'(1));
        chk("t4_inc_en", 64'(inc_en), 64'(0));
        cycle();
        chk("t4_valid_after", 64'(instr_valid), 64'(0));
        ready_on_ack = 1'b0;
        flush_need_valid = 1'b0;
        ready_pct = 100;
        pop_log.delete();
        wait_pops(1, 40, "t4_resume");
        if (pop_log.size() != 0) chk("t4_first_pc", 64'(pop_log[0].pc), 64'(14'h40));

        // 5: reset while a request for address 5 is outstanding
        lat_min = 6;
        lat_max = 6;
        do_reset();
        k = 0;
        while (!(mem_req && mem_addr == 14'd5) && k < 100) begin
            cycle();
            k++;
        end
        chk("t5_reached_5", 64'(mem_req && mem_addr == 14'd5), 64'(1));
        do_reset();
        cycle();
        chk("t5_mem_req", 64'(mem_req), 64'(0));
        chk("t5_valid", 64'(instr_valid), 64'(0));
        chk("t5_inc_en", 64'(inc_en), 64'(0));
        lat_min = 1;
        lat_max = 1;
        pop_log.delete();
        wait_pops(1, 40, "t5_resume");
        if (pop_log.size() != 0) chk("t5_first_pc", 64'(pop_log[0].pc), 64'(0));

        // 6: address wrap through the top of the space
        one_shot_target = 14'h3FFE;
        one_shot_flush = 1'b1;
        cycle();
        pop_log.delete();
        wait_pops(3, 40, "t6_words");
        if (pop_log.size() >= 3) begin
            chk("t6_pc0", 64'(pop_log[0].pc), 64'(14'h3FFE));
            chk("t6_pc1", 64'(pop_log[1].pc), 64'(14'h3FFF));
            chk("t6_pc2", 64'(pop_log[2].pc), 64'(14'h0000));
        end

        // Random traffic: variable latency, backpressure and jumps
        lat_min = 1;
        lat_max = 4;
        ready_pct = 70;
        flush_pct = 4;
        for (int i = 0; i < 600; i++) cycle();
        flush_pct = 0;
        ready_pct = 100;
        for (int i = 0; i < 20; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction-fetch stage directly downstream of the program counter (`pc`).
- Takes the current PC address, issues one read at a time to instruction memory and buffers returned words in a small FIFO.
- Presents each word, tagged with its PC, to decode over a valid/ready handshake.
- Drives `pc.inc_en` so the PC advances exactly once per accepted fetch.
- On a taken jump (`flush`), discards buffered and in-flight fetches.

Parameters:
- ADDR_W, 14, PC/instruction address width; matches `pc.in_addr`/`out_addr`.
- DATA_W, 32, instruction word width.
- BUF_DEPTH, 2, output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_addr  input  ADDR_W  current PC (`pc.out_addr`).
- inc_en  output  1  to `pc.inc_en`; PC advances at the next edge.
- flush  input  1  jump taken this cycle (same cycle as `pc.jump_en`).
- mem_req  output  1  memory read request; held until acked.
- mem_addr  output  ADDR_W  read address; stable while `mem_req`=1.
- mem_ack  input  1  one-cycle pulse; `mem_rdata` valid this cycle.
- mem_rdata  input  DATA_W  instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode accepts the head.
- instr  output  DATA_W  FIFO head word.
- instr_pc  output  ADDR_W  address the head word was fetched from.

Behaviour:
- **Reset.** On `reset` at a clock edge:
  - state=IDLE;
  - `mem_req`=0, `mem_addr`=0;
  - FIFO count=0, pointers=0;
  - `instr_valid`=0, `instr`=0, `instr_pc`=0;
  - `inc_en`=0.
- **Reset mid-request.** Reset during REQ/DRAIN drops `mem_req` immediately. Memory shares this reset, so no stale ack follows.
- **FSM states:**
  - IDLE: no request outstanding.
  - REQ: request outstanding; data will be kept.
  - DRAIN: request outstanding; data will be discarded.
- **IDLE:**
  - If !`flush` and FIFO count < BUF_DEPTH: register `mem_addr`<=`pc_addr`, `mem_req`<=1, go to REQ.
  - Otherwise stay in IDLE.
- **REQ, `mem_ack`=1, `flush`=0:**
  - Push {`mem_addr`, `mem_rdata`} into the FIFO.
  - `inc_en`=1, combinational, this cycle only.
  - `mem_req`<=0, go to IDLE.
- **REQ, `mem_ack`=1, `flush`=1:** discard data, `inc_en`=0, `mem_req`<=0, go to IDLE.
- **REQ, `mem_ack`=0, `flush`=1:** go to DRAIN; `mem_req` and `mem_addr` unchanged. The memory protocol cannot abort.
- **DRAIN:**
  - On `mem_ack`: discard data, `mem_req`<=0, go to IDLE.
  - `flush` in DRAIN has no further effect.
- **inc_en:** asserted only in the REQ+ack+!flush case. Never asserted in IDLE or DRAIN.
- **Latency and throughput:**
  - Minimum 2 cycles per fetch: IDLE issue, then REQ with ack in the first REQ cycle.
  - The pushed word is visible on `instr_valid` the cycle after ack.
  - The next issue uses `pc_addr` already incremented by `pc`.
- **FIFO:**
  - Pop when `instr_valid` && `instr_ready`.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible: issue requires count < BUF_DEPTH, and only one request is ever in flight.
  - `instr`/`instr_pc` are read combinationally from the head entry.
  - Outputs are don't-care when `instr_valid`=0; verification must not check them then.
- **flush effect on FIFO:**
  - Count and pointers cleared at the edge; `instr_valid`=0 the next cycle.
  - A pop or push in the flush cycle is ignored.
  - The IDLE issue is suppressed in the flush cycle, so the first post-jump fetch uses the new `pc_addr` one cycle later.
- **Address wrap:** PC wrap-around is owned by `pc`. `ifetch` carries addresses verbatim, ADDR_W bits, no arithmetic.
- **Handshake rule:** `instr`/`instr_pc` stay stable while `instr_valid`=1 and !`instr_ready`.

Decomposition:
- Shared package `riscy_pkg`:
  - ADDR_W=14 and DATA_W=32 constants;
  - fetch-state enum {IDLE, REQ, DRAIN}.
- One sub-module, `ifetch_fifo`: synchronous FIFO with parameters DEPTH and WIDTH=ADDR_W+DATA_W, and ports push, pop, clear, count, head.
- FSM and `inc_en` logic stay in `ifetch`.

Test Plan:
1. **Reset then free-run.**
   - Stimulus: `pc` from 0; memory acks 1 cycle after each req, `mem_rdata`=addr+32'h100; `instr_ready`=1.
   - Required: `instr_pc` sequence 0,1,2,3 with `instr` 32'h100..32'h103, one word every 2 cycles; exactly one `inc_en` pulse per word.
2. **Backpressure.**
   - Stimulus: `instr_ready`=0 for 20 cycles.
   - Required: exactly 2 words buffered (pc 0,1), `mem_req` stays 0 afterwards, PC=2, `instr` stable at 32'h100.
   - Then `instr_ready`=1: words 0,1,2 delivered in order, with no loss or duplication.
3. **Flush with request in flight.**
   - Stimulus: memory latency 4; `flush` with jump to 14'h200 in the 2nd REQ cycle.
   - Required: DRAIN, stale ack data dropped, no `inc_en`, FIFO empty; next `mem_addr`=14'h200; first delivered `instr_pc`=14'h200.
4. **Flush coincident with ack and with pop.**
   - Stimulus: `flush` in the same cycle as `mem_ack` and a head pop.
   - Required: `inc_en`=0, FIFO count 0 next cycle, `instr_valid`=0; no stale word ever appears.
5. **Reset mid-request.**
   - Stimulus: `reset` pulsed while in REQ at addr 5.
   - Required: next cycle `mem_req`=0, `instr_valid`=0, state IDLE; fetch resumes from `pc`'s reset value 0.
6. **Address wrap.**
   - Stimulus: `pc` jumps to 14'h3FFE, free-run.
   - Required: delivered `instr_pc` 3FFE, 3FFF, 0000 in order.
